// File: rtl/fadd_pipe_if.sv
// fadd_pipe_if: operand/result valid-ready bundle for fadd_pipe.
// The sub bit exists only when FADD_PIPE_SUB_EN is defined.
interface fadd_pipe_if #(
   parameter int W = 32
);
   logic in_valid, in_ready, out_valid, out_ready, ovf;
   logic [W-1:0] a, b, res;
`ifdef FADD_PIPE_SUB_EN
   logic sub;
   modport master(output in_valid, a, b, sub, out_ready, input in_ready, out_valid, res, ovf);
   modport slave(input in_valid, a, b, sub, out_ready, output in_ready, out_valid, res, ovf);
`else
   modport master(output in_valid, a, b, out_ready, input in_ready, out_valid, res, ovf);
   modport slave(input in_valid, a, b, out_ready, output in_ready, out_valid, res, ovf);
`endif
endinterface

// File: rtl/fadd_pipe.sv
// fadd_pipe: 3-stage pipelined IEEE-754 adder (align / add+normalise / round-to-nearest-even+pack).
// Defining FADD_PIPE_SUB_EN adds io.sub, which computes a-b by flipping b's sign up front.
module fadd_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input logic clk,
   input logic rst_n,
   fadd_pipe_if.slave io
);
   localparam int W = EXP_W + MAN_W + 1;
   localparam int F = MAN_W + 4;
   localparam logic [EXP_W-1:0] EMAX = '1;
   localparam logic [W-1:0] QBIT = {{(EXP_W + 1){1'b0}}, 1'b1, {(MAN_W - 1){1'b0}}};
   localparam logic [W-1:0] DNAN = {1'b1, EMAX, 1'b1, {(MAN_W - 1){1'b0}}};
   logic adv, v1, v2, v3;
   assign adv = !v3 || io.out_ready;
   assign io.in_ready = adv;
   assign io.out_valid = v3;
   logic a_s, b_s, a_nan, b_nan, a_inf, b_inf, swap;
   logic [EXP_W-1:0] a_e, b_e, l_e, s_e, le, se, d;
   logic [MAN_W-1:0] a_m, b_m;
   logic [F-1:0] l_f, s_f, s_al;
   logic [W-1:0] sp_val;
   always_comb begin
      a_s = io.a[W-1];
`ifdef FADD_PIPE_SUB_EN
      b_s = io.b[W-1] ^ io.sub;
`else
      b_s = io.b[W-1];
`endif
      a_e = io.a[W-2:MAN_W];
      b_e = io.b[W-2:MAN_W];
      a_m = io.a[MAN_W-1:0];
      b_m = io.b[MAN_W-1:0];
      a_nan = &a_e && |a_m;
      b_nan = &b_e && |b_m;
      a_inf = &a_e && !(|a_m);
      b_inf = &b_e && !(|b_m);
      sp_val = b_nan ? io.b | QBIT : a_nan ? io.a | QBIT :
               (a_inf && b_inf && a_s != b_s) ? DNAN : a_inf ? io.a : {b_s, io.b[W-2:0]};
      swap = {b_e, b_m} > {a_e, a_m};
      l_e = swap ? b_e : a_e;
      s_e = swap ? a_e : b_e;
      le = l_e | {{(EXP_W - 1){1'b0}}, ~|l_e};
      se = s_e | {{(EXP_W - 1){1'b0}}, ~|s_e};
      d = le - se;
      l_f = {|l_e, swap ? b_m : a_m, 3'b000};
      s_f = {|s_e, swap ? a_m : b_m, 3'b000};
      // bits pushed below the sticky position are folded into it
      s_al = (int'(d) >= MAN_W + 3) ? {{(F - 1){1'b0}}, |s_f} :
             (s_f >> d) | {{(F - 1){1'b0}}, |(s_f & ~({F{1'b1}} << d))};
   end
   logic s1_spec, s1_sign, s1_op, s1_zs;
   logic [W-1:0] s1_sp;
   logic [EXP_W-1:0] s1_e;
   logic [F-1:0] s1_l, s1_s;
   logic [F:0] sum;
   logic [F-1:0] n2;
   logic [EXP_W-1:0] e2;
   int lz, sh;
   always_comb begin
      sum = s1_op ? {1'b0, s1_l} - {1'b0, s1_s} : {1'b0, s1_l} + {1'b0, s1_s};
      lz = F;
      for (int i = 0; i < F; i++) lz = sum[i] ? F - 1 - i : lz;
      // left shift never takes the exponent below 1; what remains is denormal
      sh = lz < int'(s1_e) - 1 ? lz : int'(s1_e) - 1;
      n2 = sum[F] ? {sum[F:2], |sum[1:0]} : sum[F-1:0] << sh;
      e2 = sum[F] ? s1_e + 1'b1 : s1_e - EXP_W'(sh);
   end
   logic s2_spec, s2_sign;
   logic [W-1:0] s2_sp;
   logic [EXP_W-1:0] s2_e;
   logic [F-1:0] s2_m;
   logic rnd, inf;
   logic [MAN_W+1:0] rm;
   logic [MAN_W:0] mant;
   logic [EXP_W:0] e3;
   always_comb begin
      rnd = s2_m[2] && (s2_m[1] || s2_m[0] || s2_m[3]);
      rm = {1'b0, s2_m[F-1:3]} + {{(MAN_W + 1){1'b0}}, rnd};
      mant = rm[MAN_W+1] ? rm[MAN_W+1:1] : rm[MAN_W:0];
      e3 = {1'b0, s2_e} + {{EXP_W{1'b0}}, rm[MAN_W+1]};
      inf = e3 >= {1'b0, EMAX};
   end
   always_ff @(posedge clk)
      if (adv) begin
         s1_spec <= &a_e | &b_e;
         s1_sp <= sp_val;
         s1_sign <= swap ? b_s : a_s;
         s1_op <= a_s ^ b_s;
         s1_zs <= a_s & b_s;
         s1_e <= le;
         s1_l <= l_f;
         s1_s <= s_al;
         s2_spec <= s1_spec;
         s2_sp <= s1_sp;
         s2_sign <= |sum ? s1_sign : s1_zs;
         s2_e <= e2;
         s2_m <= n2;
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
         io.res <= '0;
         io.ovf <= 1'b0;
      end else if (adv) begin
         v1 <= io.in_valid;
         v2 <= v1;
         v3 <= v2;
         io.res <= s2_spec ? s2_sp : inf ? {s2_sign, EMAX, {MAN_W{1'b0}}} :
                   {s2_sign, e3[EXP_W-1:0] & {EXP_W{mant[MAN_W]}}, mant[MAN_W-1:0]};
         io.ovf <= !s2_spec && inf;
      end
endmodule

// File: tb/tb_fadd_pipe.sv
// tb_fadd_pipe: scoreboard bench for fadd_pipe (binary32 and a 5/10 instance) against an
// exact-integer reference adder with round-to-nearest-even.
module tb_fadd_pipe;
   logic clk = 0, rst_n = 0;
   always #5 clk = ~clk;
   fadd_pipe_if #(.W(32)) i32 ();
   fadd_pipe_if #(.W(16)) i16 ();
   fadd_pipe #(.EXP_W(8), .MAN_W(23)) u32 (.clk(clk), .rst_n(rst_n), .io(i32));
   fadd_pipe #(.EXP_W(5), .MAN_W(10)) u16 (.clk(clk), .rst_n(rst_n), .io(i16));
   typedef struct {logic [31:0] res; logic ovf; int cyc;} exp_t;
   exp_t q32[$], q16[$];
   int checks = 0, errors = 0, cyc = 0;
   bit saw_block = 0, hold_v = 0, done = 0;
   logic [32:0] hold_d;
   logic [31:0] da [13] = '{32'h3F800000, 32'h3F800000, 32'h00000001, 32'h007FFFFF, 32'h3F800000,
      32'h3F800001, 32'h7F7FFFFF, 32'h7F800000, 32'h3F800000, 32'h80000000, 32'h00000000,
      32'hFF800000, 32'h3F800000};
   logic [31:0] db [13] = '{32'h3F800000, 32'hBF800000, 32'h00000001, 32'h00000001, 32'h33800000,
      32'h33800000, 32'h7F7FFFFF, 32'hFF800000, 32'h7FA00001, 32'h80000000, 32'h80000000,
      32'h3F800000, 32'hB3800000};
   logic [32:0] dr [13] = '{33'h040000000, 33'h000000000, 33'h000000002, 33'h000800000, 33'h03F800000,
      33'h03F800002, 33'h17F800000, 33'h0FFC00000, 33'h07FE00001, 33'h080000000, 33'h000000000,
      33'h0FF800000, 33'h03F7FFFFF};
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   // exact sum as a wide integer at the smaller operand's scale, then one rounding step
   function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                           input int ew, input int mw, input logic sb);
      logic [31:0] mmask, qb, sgn, xm, ym;
      logic [299:0] ma, mb, mag, q;
      logic xs, ys, s, g, rest;
      int em, xe, ye, ea, eb, emin, p, sh, e;
      em = (1 << ew) - 1;
      mmask = (32'h1 << mw) - 1;
      qb = 32'h1 << (mw - 1);
      sgn = 32'h1 << (ew + mw);
      xs = x[ew+mw];
      ys = y[ew+mw] ^ sb;
      xe = int'((x >> mw) & 32'(em));
      ye = int'((y >> mw) & 32'(em));
      xm = x & mmask;
      ym = y & mmask;
      if (ye == em && ym != 0) return {1'b0, y | qb};
      if (xe == em && xm != 0) return {1'b0, x | qb};
      if (xe == em && ye == em && xs != ys) return {1'b0, sgn | (32'(em) << mw) | qb};
      if (xe == em) return {1'b0, x};
      if (ye == em) return {1'b0, (ys ? sgn : 32'h0) | (y & ~sgn)};
      ea = xe == 0 ? 1 : xe;
      eb = ye == 0 ? 1 : ye;
      emin = ea < eb ? ea : eb;
      ma = 300'(xe != 0 ? (xm | (32'h1 << mw)) : xm) << (ea - emin);
      mb = 300'(ye != 0 ? (ym | (32'h1 << mw)) : ym) << (eb - emin);
      if (xs == ys) begin mag = ma + mb; s = xs; end
      else if (ma >= mb) begin mag = ma - mb; s = xs; end
      else begin mag = mb - ma; s = ys; end
      if (mag == 0) s = xs & ys;
      p = -1;
      for (int i = 0; i < 300; i++) if (mag[i]) p = i;
      sh = p - mw;
      if (emin + sh < 1) sh = 1 - emin;
      e = emin + sh;
      if (sh <= 0) q = mag << (-sh);
      else begin
         q = mag >> sh;
         g = mag[sh-1];
         rest = sh > 1 && (mag & ((300'h1 << (sh - 1)) - 1)) != 0;
         if (g && (rest || q[0])) q = q + 1;
      end
      if (q[mw+1]) begin q = q >> 1; e++; end
      if (e >= em) return {1'b1, (s ? sgn : 32'h0) | (32'(em) << mw)};
      return {1'b0, (s ? sgn : 32'h0) | (q[mw] ? 32'(e) << mw : 32'h0) | (q[31:0] & mmask)};
   endfunction
   function automatic logic [31:0] rnd_op(input int ew, input int mw, input logic [31:0] r);
      int em = (1 << ew) - 1;
      int re = int'((r >> mw) & 32'(em));
      int k = $urandom_range(0, 9);
      int e = $urandom_range(0, em);
      logic [31:0] m = $urandom & ((32'h1 << mw) - 1);
      logic [31:0] sg = 32'($urandom_range(0, 1)) << (ew + mw);
      if (k == 7) return r ^ (32'h1 << (ew + mw));
      if (k < 4) e = re + $urandom_range(0, 6) - 3;
      else if (k == 4) e = 0;
      else if (k == 5) e = em;
      else if (k == 6) e = em - 1;
      if (e < 0) e = 0;
      if (e > em) e = em;
      if ($urandom_range(0, 7) == 0) m = 0;
      return sg | (32'(e) << mw) | m;
   endfunction
   function automatic logic rnd_sub();
`ifdef FADD_PIPE_SUB_EN
      return 1'($urandom_range(0, 1));
`else
      return 1'b0;
`endif
   endfunction
   // caller drives just after a rising edge; returns just after the accepting edge
   task automatic issue(input bit h, input logic [31:0] x, input logic [31:0] y, input logic s,
                        input logic [32:0] r, input bit lat);
      int n = 0;
      if (h) begin i16.a = x[15:0]; i16.b = y[15:0]; i16.in_valid = 1; end
      else begin i32.a = x; i32.b = y; i32.in_valid = 1; end
`ifdef FADD_PIPE_SUB_EN
      if (h) i16.sub = s; else i32.sub = s;
`endif
      do begin @(negedge clk); n++; end while (!(h ? i16.in_ready : i32.in_ready) && n < 200);
      if (!(h ? i16.in_ready : i32.in_ready)) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
      end else if (h) q16.push_back('{r[31:0], r[32], lat ? cyc : -1});
      else q32.push_back('{r[31:0], r[32], lat ? cyc : -1});
      @(posedge clk);
      #1;
      if (h) i16.in_valid = 0; else i32.in_valid = 0;
   endtask
   task automatic take(input bit h, input logic [31:0] r, input logic o);
      exp_t e;
      if (h ? q16.size() == 0 : q32.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL extra_result: res %h delivered, required nothing", r);
      end else begin
         e = h ? q16.pop_front() : q32.pop_front();
         chk(h ? "res16" : "res32", {o, r}, {e.ovf, e.res});
         if (e.cyc >= 0) chk("latency", cyc - e.cyc, 3);
      end
   endtask
   task automatic drain();
      int n = 0;
      while ((q32.size() != 0 || q16.size() != 0) && n < 500) begin @(negedge clk); n++; end
      chk("drain_pending", q32.size() + q16.size(), 0);
      @(posedge clk);
      #1;
   endtask
   always @(negedge clk) begin
      if (!rst_n) begin
         q32.delete();
         hold_v = 0;
      end else begin
         if (hold_v) chk("hold_stable", {i32.out_valid, i32.ovf, i32.res}, {1'b1, hold_d});
         if (i32.in_valid && !i32.in_ready) saw_block = 1;
         if (i32.out_valid && i32.out_ready) take(0, i32.res, i32.ovf);
         hold_v = i32.out_valid && !i32.out_ready;
         hold_d = {i32.ovf, i32.res};
      end
   end
   always @(negedge clk) begin
      if (!rst_n) q16.delete();
      else if (i16.out_valid && i16.out_ready) take(1, {16'h0, i16.res}, i16.ovf);
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end
   initial begin
      i32.in_valid = 0; i32.a = 0; i32.b = 0; i32.out_ready = 1;
      i16.in_valid = 0; i16.a = 0; i16.b = 0; i16.out_ready = 1;
`ifdef FADD_PIPE_SUB_EN
      i32.sub = 0; i16.sub = 0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_out_valid", i32.out_valid, 0);
      chk("rst_res", i32.res, 0);
      chk("rst_ovf", i32.ovf, 0);
      chk("rst_in_ready", i32.in_ready, 1);
      chk("rst_out_valid16", i16.out_valid, 0);
      rst_n = 1;
      @(negedge clk);
      chk("in_ready_after_rst", i32.in_ready, 1);
      chk("out_valid_after_rst", i32.out_valid, 0);
      @(posedge clk);
      #1;
      for (int i = 0; i < 13; i++) begin
         issue(0, da[i], db[i], 0, dr[i], 1);
         drain();
      end
      issue(1, 32'h3C00, 32'h3C00, 0, 33'h4000, 1);
      issue(1, 32'h3C00, 32'hBC00, 0, 33'h0000, 0);
      issue(1, 32'h7BFF, 32'h7BFF, 0, 33'h1_0000_7C00, 0);
      issue(1, 32'h0001, 32'h03FF, 0, 33'h0400, 0);
      drain();
      saw_block = 0;
      fork
         for (int k = 0; k < 6; k++) begin
            logic [31:0] x, y;
            x = rnd_op(8, 23, $urandom);
            y = rnd_op(8, 23, x);
            issue(0, x, y, 0, ref_add(x, y, 8, 23, 0), 0);
         end
         begin
            repeat (3) @(posedge clk);
            #1 i32.out_ready = 0;
            repeat (6) @(posedge clk);
            #1 i32.out_ready = 1;
         end
      join
      drain();
      chk("in_ready_dropped", saw_block, 1);
      for (int k = 0; k < 3; k++) issue(0, 32'h3F800000, 32'h3F800000, 0, 33'h040000000, 0);
      #1;
      chk("pre_rst_valid", i32.out_valid, 1);
      rst_n = 0;
      #1;
      chk("midrst_out_valid", i32.out_valid, 0);
      chk("midrst_in_ready", i32.in_ready, 1);
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
      issue(0, 32'h3F800000, 32'h40000000, 0, 33'h040400000, 1);
      drain();
      fork
         begin
            for (int k = 0; k < 400; k++) begin
               logic [31:0] x, y;
               logic s;
               x = rnd_op(8, 23, $urandom);
               y = rnd_op(8, 23, x);
               s = rnd_sub();
               issue(0, x, y, s, ref_add(x, y, 8, 23, s), 0);
               if ($urandom_range(0, 3) == 0) begin
                  repeat ($urandom_range(1, 3)) @(posedge clk);
                  #1;
               end
            end
            done = 1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1 i32.out_ready = $urandom_range(0, 9) < 7;
            end
            i32.out_ready = 1;
         end
         for (int k = 0; k < 150; k++) begin
            logic [31:0] x, y;
            logic s;
            x = rnd_op(5, 10, $urandom);
            y = rnd_op(5, 10, x);
            s = rnd_sub();
            issue(1, x, y, s, ref_add(x, y, 5, 10, s), 0);
         end
      join
      drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fadd_pipe.md
Name: fadd_pipe

Overview:
- Parametrised, 3-stage pipelined IEEE-754 binary floating-point adder with valid/ready handshakes on input and output.
- Generalises the team's combinational single-precision fadd to arbitrary exponent/mantissa widths and adds round-to-nearest-even.
- Sits between the operand-issue logic and the FPU writeback/result arbiter.

Parameters:
- EXP_W, 8: exponent field width (≥3).
- MAN_W, 23: stored mantissa field width, without the hidden bit (≥2).
- W, EXP_W+MAN_W+1: operand and result width. Derived; not overridable.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands a and b are valid this cycle
- in_ready  out  1  block accepts operands this cycle
- a  in  W  operand A
- b  in  W  operand B
- out_valid  out  1  res and ovf are valid
- out_ready  in  1  consumer accepts the result this cycle
- res  out  W  sum
- ovf  out  1  finite operands rounded to infinity

Interface rule: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset: clears all stage valid bits. out_valid=0, res=0, ovf=0, in_ready=1 while rst_n=0 and the cycle after release. Data registers need not reset.
- Pipeline enable: adv = !out_valid || out_ready. All three stages advance together when adv=1.
- Handshake: in_ready = adv. An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Bubbles are not collapsed. Latency is exactly 3 cycles from the accepting edge when never stalled. Throughput is 1/cycle.
- While out_valid && !out_ready: res, ovf and out_valid hold stable, and in_ready=0.
- Stage 1, unpack/compare/align:
  - Order the operands by magnitude (|exp|, then mantissa; a wins ties). Swap signs with the operands.
  - Hidden bit = (exp≠0). Denormal effective exponent = 1.
  - Shift the smaller operand right by the exponent difference into a mantissa extended by guard, round and sticky bits. The sticky bit ORs every bit shifted past.
  - Shift amounts ≥ MAN_W+3 leave only the sticky bit.
- Stage 2, add/sub and normalise:
  - Same signs: add. Different signs: subtract smaller from larger.
  - Carry-out: shift right 1 and exp+1. Sticky keeps the shifted-out bit.
  - Otherwise use a leading-zero count and shift left by min(lzc, exp-1). If that limit is reached, the result is denormal with exp field 0.
- Stage 3, round/pack:
  - Round to nearest even: increment when g && (r|s|lsb).
  - Mantissa carry on rounding gives exp+1. A denormal that rounds up to the hidden bit becomes exp=1.
  - exp reaching all-ones gives ±inf with ovf=1.
- Special cases (decided in stage 1, carried as a flag; no arithmetic path used):
  - b NaN → b with the quiet bit (MSB of mantissa) forced to 1. Else a NaN → same treatment on a.
  - +inf + -inf → {1, all-ones exp, 1, zeros}.
  - Otherwise any inf → that inf. ovf=0 in all special cases.
- Exact zero:
  - Opposite signs with equal magnitude → +0.
  - (+0)+(+0) → +0; (-0)+(-0) → -0.
- Reset asserted mid-operation discards all in-flight results. No partial output is produced.

Optional Feature:
- Macro FADD_PIPE_SUB_EN.
- Defined: adds input port sub (1 bit), sampled with a/b on the input transfer. When sub=1, b's sign is inverted before every stage-1 decision, including inf-inf and NaN handling. NaN payload and sign are passed unmodified.
- Undefined: the sub port does not exist. The block always computes a+b.

Test Plan:
- 0x3F800000+0x3F800000, out_ready=1 → res=0x40000000, ovf=0, out_valid exactly 3 cycles after the accept edge.
- 0x3F800000+0xBF800000 → 0x00000000. Also 0x00000001+0x00000001 → 0x00000002 (denormal). Also 0x007FFFFF+0x00000001 → 0x00800000 (promotion).
- RNE: 0x3F800000+0x33800000 → 0x3F800000 (tie, even). 0x3F800001+0x33800000 → 0x3F800002 (tie, odd rounds up).
- 0x7F7FFFFF+0x7F7FFFFF → 0x7F800000, ovf=1. 0x7F800000+0xFF800000 → 0xFFC00000, ovf=0. 0x3F800000+0x7FA00001 → 0x7FE00001.
- Back-to-back issue of 6 operand pairs with out_ready low for cycles 4–9 → in_ready drops once the pipe is full, res is held stable, all 6 results arrive in order with none lost or duplicated.
- Assert rst_n=0 with 3 results in flight → out_valid=0 immediately. After release, the first new result has the correct value. Also instantiate EXP_W=5, MAN_W=10: 0x3C00+0x3C00 → 0x4000.
